// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the 5-stage core: stall hold, flush bubbles,
// exception merging with nullification, and bubbles that can keep PC/BD for EPC.
module pipe_stage_reg #(
    parameter int          DATA_W        = 96,
    parameter int          TNEW_W        = 2,
    parameter int          EXC_W         = 5,
    parameter int          TNEW_DEC      = 1,
    parameter bit          FLUSH_KEEP_PC = 1'b1,
    parameter logic [31:0] RESET_PC      = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [31:0]       instr_in,
    input  logic [31:0]       pc_in,
    input  logic              bd_in,
    input  logic [DATA_W-1:0] payload_in,
    input  logic [4:0]        waddr_in,
    input  logic [TNEW_W-1:0] tnew_in,
    input  logic [EXC_W-1:0]  exc_in,
    input  logic [EXC_W-1:0]  exc_local,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc8_out,
    output logic              bd_out,
    output logic [DATA_W-1:0] payload_out,
    output logic [4:0]        waddr_out,
    output logic [TNEW_W-1:0] tnew_out,
    output logic [EXC_W-1:0]  exc_out,
    output logic              valid_out,
    output logic              exc_pending
);

    localparam logic [TNEW_W-1:0] TNEW_DEC_L = TNEW_DEC[TNEW_W-1:0];

    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_q, pc_d;
    logic              bd_q, bd_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic              valid_q, valid_d;

    logic [EXC_W-1:0]  exc_m;
    logic [TNEW_W-1:0] tnew_sat;

    // The older stage's exception is the architecturally earlier one, so it wins.
    assign exc_m    = (exc_in != '0) ? exc_in : exc_local;
    assign tnew_sat = (tnew_in > TNEW_DEC_L) ? (tnew_in - TNEW_DEC_L) : '0;

    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        bd_d      = bd_q;
        payload_d = payload_q;
        waddr_d   = waddr_q;
        tnew_d    = tnew_q;
        exc_d     = exc_q;
        valid_d   = valid_q;
        if (flush) begin
            instr_d   = '0;
            payload_d = '0;
            waddr_d   = '0;
            tnew_d    = '0;
            exc_d     = '0;
            valid_d   = 1'b0;
            pc_d      = FLUSH_KEEP_PC ? pc_in : 32'h0;
            bd_d      = FLUSH_KEEP_PC ? bd_in : 1'b0;
        end else if (!stall) begin
            pc_d  = pc_in;
            bd_d  = bd_in;
            exc_d = exc_m;
            if (!valid_in) begin
                // Invalid slot still reports its exception so the fault is visible.
                instr_d   = '0;
                payload_d = '0;
                waddr_d   = '0;
                tnew_d    = '0;
                valid_d   = 1'b0;
            end else begin
                instr_d   = instr_in;
                payload_d = payload_in;
                valid_d   = 1'b1;
                // A faulting instruction must never be forwarded or written back.
                waddr_d   = (exc_m != '0) ? 5'd0 : waddr_in;
                tnew_d    = (exc_m != '0) ? '0   : tnew_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= '0;
            pc_q      <= RESET_PC;
            bd_q      <= 1'b0;
            payload_q <= '0;
            waddr_q   <= '0;
            tnew_q    <= '0;
            exc_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            bd_q      <= bd_d;
            payload_q <= payload_d;
            waddr_q   <= waddr_d;
            tnew_q    <= tnew_d;
            exc_q     <= exc_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign pc8_out     = pc_q + 32'd8;
    assign bd_out      = bd_q;
    assign payload_out = payload_q;
    assign waddr_out   = waddr_q;
    assign tnew_out    = tnew_q;
    assign exc_out     = exc_q;
    assign valid_out   = valid_q;
    assign exc_pending = valid_q & (exc_q != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: two instances (default parameters, and TNEW_DEC=0 with
// cleared-PC bubbles) driven in lockstep; expected register contents are queued and checked.
module tb_pipe_stage_reg;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bd;
        logic [95:0] payload;
        logic [4:0]  waddr;
        logic [1:0]  tnew;
        logic [4:0]  exc;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in, bd_in;
    logic [31:0] instr_in, pc_in;
    logic [95:0] payload_in;
    logic [4:0]  waddr_in, exc_in, exc_local;
    logic [1:0]  tnew_in;

    logic [31:0] a_instr, a_pc, a_pc8, b_instr, b_pc, b_pc8;
    logic        a_bd, a_valid, a_pend, b_bd, b_valid, b_pend;
    logic [95:0] a_payload, b_payload;
    logic [4:0]  a_waddr, a_exc, b_waddr, b_exc;
    logic [1:0]  a_tnew, b_tnew;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .instr_in(instr_in), .pc_in(pc_in), .bd_in(bd_in), .payload_in(payload_in),
        .waddr_in(waddr_in), .tnew_in(tnew_in), .exc_in(exc_in), .exc_local(exc_local),
        .instr_out(a_instr), .pc_out(a_pc), .pc8_out(a_pc8), .bd_out(a_bd),
        .payload_out(a_payload), .waddr_out(a_waddr), .tnew_out(a_tnew), .exc_out(a_exc),
        .valid_out(a_valid), .exc_pending(a_pend)
    );

    pipe_stage_reg #(.TNEW_DEC(0), .FLUSH_KEEP_PC(1'b0)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .instr_in(instr_in), .pc_in(pc_in), .bd_in(bd_in), .payload_in(payload_in),
        .waddr_in(waddr_in), .tnew_in(tnew_in), .exc_in(exc_in), .exc_local(exc_local),
        .instr_out(b_instr), .pc_out(b_pc), .pc8_out(b_pc8), .bd_out(b_bd),
        .payload_out(b_payload), .waddr_out(b_waddr), .tnew_out(b_tnew), .exc_out(b_exc),
        .valid_out(b_valid), .exc_pending(b_pend)
    );

    function automatic exp_t ex(string nm, logic [31:0] ins, logic [31:0] pc, logic bd,
                                logic [95:0] pl, logic [4:0] wa, logic [1:0] tn,
                                logic [4:0] ec, logic v);
        exp_t e;
        e.name = nm; e.instr = ins; e.pc = pc; e.bd = bd; e.payload = pl;
        e.waddr = wa; e.tnew = tn; e.exc = ec; e.valid = v;
        return e;
    endfunction

    task automatic check(int id, exp_t e, logic [31:0] ins, logic [31:0] pc, logic [31:0] pc8,
                         logic bd, logic [95:0] pl, logic [4:0] wa, logic [1:0] tn,
                         logic [4:0] ec, logic v, logic pend);
        logic [31:0] e_pc8;
        logic        e_pend;
        e_pc8  = e.pc + 32'd8;
        e_pend = e.valid && (e.exc != 5'd0);
        n_cmp++;
        if (ins !== e.instr || pc !== e.pc || pc8 !== e_pc8 || bd !== e.bd || pl !== e.payload ||
            wa !== e.waddr || tn !== e.tnew || ec !== e.exc || v !== e.valid || pend !== e_pend) begin
            n_bad++;
            $display("FAIL %s dut%0d: got instr=%h pc=%h pc8=%h bd=%b pl=%h wa=%0d tn=%0d exc=%0d v=%b pend=%b | need instr=%h pc=%h pc8=%h bd=%b pl=%h wa=%0d tn=%0d exc=%0d v=%b pend=%b",
                     e.name, id, ins, pc, pc8, bd, pl, wa, tn, ec, v, pend,
                     e.instr, e.pc, e_pc8, e.bd, e.payload, e.waddr, e.tnew, e.exc, e.valid, e_pend);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() != 0)
            check(0, qa.pop_front(), a_instr, a_pc, a_pc8, a_bd, a_payload, a_waddr, a_tnew, a_exc, a_valid, a_pend);
        if (qb.size() != 0)
            check(1, qb.pop_front(), b_instr, b_pc, b_pc8, b_bd, b_payload, b_waddr, b_tnew, b_exc, b_valid, b_pend);
    end

    task automatic step(logic r, logic s, logic f, logic v, logic [31:0] ins, logic [31:0] pc,
                        logic bd, logic [95:0] pl, logic [4:0] wa, logic [1:0] tn,
                        logic [4:0] ei, logic [4:0] el, exp_t ea, exp_t eb);
        reset = r; stall = s; flush = f; valid_in = v; instr_in = ins; pc_in = pc;
        bd_in = bd; payload_in = pl; waddr_in = wa; tnew_in = tn; exc_in = ei; exc_local = el;
        @(posedge clk);
        #1;
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    initial begin
        exp_t rst_e, e5a, e5b, e15a, e15b;
        rst_e = ex("reset", 0, 32'h3000, 0, 0, 0, 0, 0, 0);
        step(1,0,0,1, 32'h5, 32'h1234, 1, 96'h9, 3, 2, 0, 0, rst_e, rst_e);
        step(0,0,0,1, 32'h0109_5020, 32'h3004, 0, 96'hAB, 10, 2, 0, 0,
             ex("load_basic", 32'h0109_5020, 32'h3004, 0, 96'hAB, 10, 1, 0, 1),
             ex("load_basic", 32'h0109_5020, 32'h3004, 0, 96'hAB, 10, 2, 0, 1));
        step(0,0,0,1, 32'h11, 32'h3008, 0, 96'h1, 3, 0, 0, 0,
             ex("tnew0_sat", 32'h11, 32'h3008, 0, 96'h1, 3, 0, 0, 1),
             ex("tnew0_sat", 32'h11, 32'h3008, 0, 96'h1, 3, 0, 0, 1));
        step(0,0,0,1, 32'h22, 32'h300C, 0, 96'h2, 4, 1, 0, 0,
             ex("tnew1_sat", 32'h22, 32'h300C, 0, 96'h2, 4, 0, 0, 1),
             ex("tnew1_sat", 32'h22, 32'h300C, 0, 96'h2, 4, 1, 0, 1));
        e5a = ex("stall_hold", 32'h33, 32'h3010, 1, 96'hCD, 5, 2, 0, 1);
        e5b = ex("stall_hold", 32'h33, 32'h3010, 1, 96'hCD, 5, 3, 0, 1);
        step(0,0,0,1, 32'h33, 32'h3010, 1, 96'hCD, 5, 3, 0, 0, e5a, e5b);
        for (int i = 0; i < 3; i++)
            step(0,1,0,1, 32'h44, 32'h3014, 0, 96'hEF, 6, 2, 0, 0, e5a, e5b);
        step(0,0,0,1, 32'h44, 32'h3014, 0, 96'hEF, 6, 2, 0, 0,
             ex("stall_release", 32'h44, 32'h3014, 0, 96'hEF, 6, 1, 0, 1),
             ex("stall_release", 32'h44, 32'h3014, 0, 96'hEF, 6, 2, 0, 1));
        step(0,1,1,1, 32'h55, 32'h3020, 1, 96'h7, 7, 2, 0, 3,
             ex("flush_stall", 0, 32'h3020, 1, 0, 0, 0, 0, 0),
             ex("flush_stall", 0, 32'h0, 0, 0, 0, 0, 0, 0));
        step(0,0,0,1, 32'h66, 32'h3024, 0, 96'h8, 8, 2, 0, 12,
             ex("exc_local_null", 32'h66, 32'h3024, 0, 96'h8, 0, 0, 12, 1),
             ex("exc_local_null", 32'h66, 32'h3024, 0, 96'h8, 0, 0, 12, 1));
        step(0,0,0,1, 32'h77, 32'h3028, 0, 96'h9, 9, 2, 4, 12,
             ex("exc_merge", 32'h77, 32'h3028, 0, 96'h9, 0, 0, 4, 1),
             ex("exc_merge", 32'h77, 32'h3028, 0, 96'h9, 0, 0, 4, 1));
        step(0,0,0,0, 32'h88, 32'h302C, 1, 96'h12, 11, 2, 0, 0,
             ex("invalid_slot", 0, 32'h302C, 1, 0, 0, 0, 0, 0),
             ex("invalid_slot", 0, 32'h302C, 1, 0, 0, 0, 0, 0));
        step(0,0,0,0, 32'h89, 32'h3030, 0, 96'h13, 11, 2, 0, 6,
             ex("invalid_exc", 0, 32'h3030, 0, 0, 0, 0, 6, 0),
             ex("invalid_exc", 0, 32'h3030, 0, 0, 0, 0, 6, 0));
        e15a = ex("pre_reset", 32'h99, 32'h3040, 0, 96'h14, 12, 0, 0, 1);
        e15b = ex("pre_reset", 32'h99, 32'h3040, 0, 96'h14, 12, 1, 0, 1);
        step(0,0,0,1, 32'h99, 32'h3040, 0, 96'h14, 12, 1, 0, 0, e15a, e15b);
        step(0,1,0,1, 32'hA0, 32'h3044, 1, 96'h15, 13, 3, 0, 0, e15a, e15b);
        step(1,1,1,1, 32'hA0, 32'h3044, 1, 96'h15, 13, 3, 0, 0, rst_e, rst_e);
        step(0,0,0,1, 32'hAA, 32'hFFFF_FFFC, 0, 96'h16, 1, 0, 0, 0,
             ex("pc8_wrap", 32'hAA, 32'hFFFF_FFFC, 0, 96'h16, 1, 0, 0, 1),
             ex("pc8_wrap", 32'hAA, 32'hFFFF_FFFC, 0, 96'h16, 1, 0, 0, 1));
        for (int i = 0; i < 5 && (qa.size() != 0 || qb.size() != 0); i++)
            @(posedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, need 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
